// File: rtl/demux_1_4_stream_if.sv
// Stream bundle for the 1-to-4 packet demultiplexer: one input stream
// fanned out to four independently handshaked output channels.
interface demux_1_4_stream_if #(
  parameter int unsigned DATA_W = 8
);
  logic [1:0]          s;
  logic                i_valid;
  logic                i_ready;
  logic [DATA_W-1:0]   i_data;
  logic                i_last;
  logic [3:0]          f_valid;
  logic [3:0]          f_ready;
  logic [4*DATA_W-1:0] f_data;
  logic [3:0]          f_last;
  logic                busy;

  modport master (
    output s, i_valid, i_data, i_last, f_ready,
    input  i_ready, f_valid, f_data, f_last, busy
  );

  modport slave (
    input  s, i_valid, i_data, i_last, f_ready,
    output i_ready, f_valid, f_data, f_last, busy
  );
endinterface

// File: rtl/demux_1_4_stream.sv
// 1-to-4 packet demultiplexer: the channel is chosen on the first beat of a
// packet and held until the last beat; each channel has a one-entry skid register.
module demux_1_4_stream #(
  parameter int unsigned DATA_W = 8
) (
  input logic               clk,
  input logic               rst_n,
  demux_1_4_stream_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t              state_q;
  logic [1:0]          sel_q;
  logic [1:0]          ch;
  logic                accept;
  logic [3:0]          fv_q, fv_d;
  logic [3:0]          fl_q, fl_d;
  logic [4*DATA_W-1:0] fd_q, fd_d;

  // The select input only matters at a packet boundary.
  assign ch     = (state_q == BUSY) ? sel_q : bus.s;
  assign accept = bus.i_valid & bus.i_ready;

  assign bus.i_ready = ~fv_q[ch] | bus.f_ready[ch];
  assign bus.f_valid = fv_q;
  assign bus.f_data  = fd_q;
  assign bus.f_last  = fl_q;
  assign bus.busy    = (state_q == BUSY);

  // A load wins over a drain on the same channel, so a full register that is
  // being emptied refills in the same cycle without a bubble.
  always_comb begin
    fv_d = fv_q;
    fl_d = fl_q;
    fd_d = fd_q;
    for (int unsigned k = 0; k < 4; k++) begin
      if (accept && (ch == 2'(k))) begin
        fv_d[k]                  = 1'b1;
        fl_d[k]                  = bus.i_last;
        fd_d[k*DATA_W +: DATA_W] = bus.i_data;
      end else if (fv_q[k] && bus.f_ready[k]) begin
        fv_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      fv_q    <= '0;
      fl_q    <= '0;
      fd_q    <= '0;
    end else begin
      fv_q <= fv_d;
      fl_q <= fl_d;
      fd_q <= fd_d;
      case (state_q)
        IDLE: begin
          if (accept && !bus.i_last) begin
            state_q <= BUSY;
            sel_q   <= bus.s;
          end
        end
        BUSY: begin
          if (accept && bus.i_last) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Self-checking bench for demux_1_4_stream: per-channel expected-beat queues
// filled on accepted input beats and drained as channels hand off output.
module tb_demux_1_4_stream;

  localparam int unsigned DATA_W = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  demux_1_4_stream_if #(.DATA_W(DATA_W)) bus ();

  demux_1_4_stream #(.DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } ent_t;

  typedef struct {
    logic [1:0] s;
    logic [7:0] d;
    logic       l;
    logic [3:0] exp_fv;
    logic       exp_busy;
    int         exp_ch;
  } vec_t;

  ent_t sbq [4][$];
  logic m_busy;
  logic [1:0] m_sel;
  int total = 0;
  int bad   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [7:0] lane(int k);
    return bus.f_data[k*DATA_W +: DATA_W];
  endfunction

  // Reference model: runs on the falling edge, predicting what the next rising edge does.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) sbq[k].delete();
      m_busy = 1'b0;
      m_sel  = 2'd0;
    end else begin
      logic [1:0] mch;
      logic       mrdy;
      ent_t       e;
      mch  = m_busy ? m_sel : bus.s;
      mrdy = (sbq[mch].size() == 0) || bus.f_ready[mch];
      chk("busy", 32'(bus.busy), 32'(m_busy));
      if (bus.i_valid) chk("i_ready", 32'(bus.i_ready), 32'(mrdy));
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("f_valid%0d", k), 32'(bus.f_valid[k]), 32'(sbq[k].size() != 0));
        if (bus.f_valid[k] && bus.f_ready[k] && sbq[k].size() > 0) begin
          e = sbq[k].pop_front();
          chk($sformatf("data%0d", k), 32'(lane(k)), 32'(e.d));
          chk($sformatf("last%0d", k), 32'(bus.f_last[k]), 32'(e.l));
        end
      end
      if (bus.i_valid && mrdy) begin
        sbq[mch].push_back('{d: bus.i_data, l: bus.i_last});
        if (!m_busy && !bus.i_last) begin
          m_busy = 1'b1;
          m_sel  = bus.s;
        end else if (m_busy && bus.i_last) begin
          m_busy = 1'b0;
        end
      end
    end
  end

  // Offer one beat and hold it until accepted; returns just after the accepting edge.
  task automatic send(input logic [1:0] s, input logic [7:0] d, input logic l);
    bit acc = 0;
    bus.s       = s;
    bus.i_data  = d;
    bus.i_last  = l;
    bus.i_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.i_ready) begin
        acc = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  vec_t tbl [6];

  initial begin
    tbl[0] = '{s: 2'd0, d: 8'h3C, l: 1'b1, exp_fv: 4'b0001, exp_busy: 1'b0, exp_ch: 0};
    tbl[1] = '{s: 2'd1, d: 8'h5A, l: 1'b1, exp_fv: 4'b0010, exp_busy: 1'b0, exp_ch: 1};
    tbl[2] = '{s: 2'd2, d: 8'hA5, l: 1'b1, exp_fv: 4'b0100, exp_busy: 1'b0, exp_ch: 2};
    tbl[3] = '{s: 2'd3, d: 8'hFF, l: 1'b1, exp_fv: 4'b1000, exp_busy: 1'b0, exp_ch: 3};
    tbl[4] = '{s: 2'd1, d: 8'hD1, l: 1'b0, exp_fv: 4'b0010, exp_busy: 1'b1, exp_ch: 1};
    tbl[5] = '{s: 2'd3, d: 8'hD2, l: 1'b1, exp_fv: 4'b0010, exp_busy: 1'b0, exp_ch: 1};

    rst_n       = 1'b0;
    bus.s       = 2'd0;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_last  = 1'b0;
    bus.f_ready = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_i_ready", 32'(bus.i_ready), 32'd1);
    chk("rst_busy",    32'(bus.busy),    32'd0);
    chk("rst_f_valid", 32'(bus.f_valid), 32'd0);
    chk("rst_f_last",  32'(bus.f_last),  32'd0);
    chk("rst_f_data",  32'(bus.f_data),  32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single beats, including a short packet whose select changes mid-packet
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].s, tbl[i].d, tbl[i].l);
      chk($sformatf("tbl%0d_fv", i),   32'(bus.f_valid), 32'(tbl[i].exp_fv));
      chk($sformatf("tbl%0d_data", i), 32'(lane(tbl[i].exp_ch)), 32'(tbl[i].d));
      chk($sformatf("tbl%0d_last", i), 32'(bus.f_last[tbl[i].exp_ch]), 32'(tbl[i].l));
      chk($sformatf("tbl%0d_busy", i), 32'(bus.busy), 32'(tbl[i].exp_busy));
    end

    // Select lock
    send(2'd1, 8'h11, 1'b0);
    chk("lock_busy1", 32'(bus.busy), 32'd1);
    chk("lock_fv1",   32'(bus.f_valid), 32'b0010);
    send(2'd3, 8'h22, 1'b0);
    chk("lock_fv2",   32'(bus.f_valid), 32'b0010);
    chk("lock_d2",    32'(lane(1)), 32'h22);
    send(2'd3, 8'h33, 1'b1);
    chk("lock_busy3", 32'(bus.busy), 32'd0);
    chk("lock_fv3",   32'(bus.f_valid), 32'b0010);
    chk("lock_d3",    32'(lane(1)), 32'h33);
    @(posedge clk);
    #1;

    // Backpressure on channel 0
    bus.f_ready = 4'b1110;
    send(2'd0, 8'h44, 1'b1);
    chk("bp_d1", 32'(lane(0)), 32'h44);
    bus.s       = 2'd0;
    bus.i_data  = 8'h55;
    bus.i_last  = 1'b1;
    bus.i_valid = 1'b1;
    @(negedge clk);
    chk("bp_rdy_lo1", 32'(bus.i_ready), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_rdy_lo2", 32'(bus.i_ready), 32'd0);
    chk("bp_hold",    32'(lane(0)), 32'h44);
    @(posedge clk);
    #1;
    bus.f_ready = 4'b1111;
    @(negedge clk);
    chk("bp_rdy_hi", 32'(bus.i_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    chk("bp_d2",  32'(lane(0)), 32'h55);
    chk("bp_fv2", 32'(bus.f_valid), 32'b0001);
    @(posedge clk);
    #1;
    chk("bp_empty", 32'(bus.f_valid), 32'd0);

    // Independent drain while channel 3 is stalled
    bus.f_ready = 4'b0111;
    send(2'd3, 8'h77, 1'b1);
    send(2'd0, 8'h01, 1'b0);
    send(2'd0, 8'h02, 1'b1);
    chk("ind_fv",  32'(bus.f_valid), 32'b1001);
    chk("ind_d3",  32'(lane(3)), 32'h77);
    chk("ind_d0",  32'(lane(0)), 32'h02);
    @(posedge clk);
    #1;
    chk("ind_fv2", 32'(bus.f_valid), 32'b1000);
    chk("ind_d3b", 32'(lane(3)), 32'h77);
    bus.f_ready = 4'b1111;
    @(posedge clk);
    #1;
    chk("ind_fv3", 32'(bus.f_valid), 32'd0);

    // Full throughput, 8 beats back to back on channel 2
    bus.s = 2'd2;
    for (int i = 0; i < 8; i++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = 8'h80 + 8'(i);
      bus.i_last  = (i == 7);
      @(negedge clk);
      chk("tput_rdy", 32'(bus.i_ready), 32'd1);
      @(posedge clk);
      #1;
    end
    bus.i_valid = 1'b0;
    chk("tput_d",    32'(lane(2)), 32'h87);
    chk("tput_last", 32'(bus.f_last[2]), 32'd1);
    chk("tput_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;

    // Reset in the middle of a packet
    send(2'd1, 8'h61, 1'b0);
    send(2'd1, 8'h62, 1'b0);
    chk("mr_busy_pre", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_fv",   32'(bus.f_valid), 32'd0);
    chk("mr_busy", 32'(bus.busy), 32'd0);
    chk("mr_data", 32'(bus.f_data), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(2'd0, 8'hC3, 1'b1);
    chk("mr_fv2",   32'(bus.f_valid), 32'b0001);
    chk("mr_d0",    32'(lane(0)), 32'hC3);
    chk("mr_busy2", 32'(bus.busy), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) chk($sformatf("sb_empty%0d", k), 32'(sbq[k].size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
